// File: rtl/pkt_route_ctrl.sv
// Routes USB3 receive-cache words into the 24 channel RAMs (C/A, NAV, bulk)
// by parsing header words and sequencing payload into bank/address slots.
module pkt_route_ctrl #(
  parameter int unsigned CA_WORDS  = 32,
  parameter int unsigned NAV_WORDS = 10,
  parameter int unsigned BULK_MAX  = 256
) (
  input  logic        rdclock,
  input  logic        rst_n,
  input  logic [31:0] din,
  input  logic        din_valid,
  input  logic        frame_end,
  output logic [23:0] wren_out,
  output logic [7:0]  wraddr,
  output logic [31:0] wdata,
  output logic        pkt_done,
  output logic        hdr_err,
  output logic        short_err,
  output logic        bulk_ovf,
  output logic        busy
);

  localparam int unsigned CA_LAST  = 8 * CA_WORDS - 1;
  localparam int unsigned NAV_LAST = 8 * NAV_WORDS - 1;

  typedef enum logic [1:0] {ST_IDLE, ST_CA, ST_NAV, ST_BULK} state_t;

  state_t      state;
  logic [8:0]  cnt;
  logic [2:0]  bank_cnt;
  logic [7:0]  addr_cnt;
  logic [2:0]  bulk_idx;

  logic        is_hdr;
  logic [15:0] subtype;
  logic [7:0]  addr_last;
  logic [8:0]  cnt_last;
  logic [4:0]  ch_sel;

  // Header decode and per-state bank/address limits
  always_comb begin
    is_hdr    = (din & 32'hFF0000FF) == 32'hFF0000AA;
    subtype   = din[23:8];
    addr_last = 8'(CA_WORDS - 1);
    cnt_last  = 9'(CA_LAST);
    ch_sel    = 5'(bank_cnt);
    case (state)
      ST_NAV: begin
        addr_last = 8'(NAV_WORDS - 1);
        cnt_last  = 9'(NAV_LAST);
        ch_sel    = 5'd8 + 5'(bank_cnt);
      end
      ST_BULK: ch_sel = 5'd16 + 5'(bulk_idx);
      default: ;
    endcase
  end

  // Controller: state, counters and registered outputs
  always_ff @(posedge rdclock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bank_cnt  <= '0;
      addr_cnt  <= '0;
      bulk_idx  <= '0;
      wren_out  <= '0;
      wraddr    <= '0;
      wdata     <= '0;
      pkt_done  <= 1'b0;
      hdr_err   <= 1'b0;
      short_err <= 1'b0;
      bulk_ovf  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wren_out  <= '0;
      wraddr    <= '0;
      wdata     <= '0;
      pkt_done  <= 1'b0;
      hdr_err   <= 1'b0;
      short_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (din_valid && is_hdr) begin
            cnt      <= '0;
            bank_cnt <= '0;
            addr_cnt <= '0;
            case (subtype)
              16'h0000: begin
                state <= ST_CA;
                busy  <= 1'b1;
              end
              16'h000A: begin
                state <= ST_NAV;
                busy  <= 1'b1;
              end
              16'h0AAA: begin
                state    <= ST_BULK;
                busy     <= 1'b1;
                bulk_ovf <= 1'b0;
              end
              16'h00AA, 16'hAAAA: begin
                bulk_idx <= '0;
                pkt_done <= 1'b1;
              end
              default: hdr_err <= 1'b1;
            endcase
          end
        end
        ST_CA, ST_NAV: begin
          if (din_valid) begin
            wren_out <= 24'(1) << ch_sel;
            wraddr   <= addr_cnt;
            wdata    <= din;
            cnt      <= cnt + 9'd1;
            // Compare-and-subtract stepping of bank/address instead of division
            if (addr_cnt == addr_last) begin
              addr_cnt <= '0;
              bank_cnt <= bank_cnt + 3'd1;
            end else begin
              addr_cnt <= addr_cnt + 8'd1;
            end
          end
          // A final word arriving with frame_end still completes the packet
          if (din_valid && (cnt == cnt_last)) begin
            pkt_done <= 1'b1;
            state    <= ST_IDLE;
            busy     <= 1'b0;
          end else if (frame_end) begin
            short_err <= 1'b1;
            state     <= ST_IDLE;
            busy      <= 1'b0;
          end
        end
        ST_BULK: begin
          if (din_valid) begin
            if (cnt < 9'(BULK_MAX)) begin
              wren_out <= 24'(1) << ch_sel;
              wraddr   <= cnt[7:0];
              wdata    <= din;
              cnt      <= cnt + 9'd1;
            end else begin
              bulk_ovf <= 1'b1;
            end
          end
          if (frame_end) begin
            pkt_done <= 1'b1;
            bulk_idx <= bulk_idx + 3'd1;
            state    <= ST_IDLE;
            busy     <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_route_ctrl.sv
// Scoreboard bench for pkt_route_ctrl: directed packets push expected output
// beats; a negedge monitor pops and compares whenever the DUT emits a beat.
module tb_pkt_route_ctrl;

  logic        rdclock;
  logic        rst_n;
  logic [31:0] din;
  logic        din_valid;
  logic        frame_end;
  logic [23:0] wren_out;
  logic [7:0]  wraddr;
  logic [31:0] wdata;
  logic        pkt_done;
  logic        hdr_err;
  logic        short_err;
  logic        bulk_ovf;
  logic        busy;

  pkt_route_ctrl #(.CA_WORDS(32), .NAV_WORDS(10), .BULK_MAX(256)) dut (
    .rdclock  (rdclock),
    .rst_n    (rst_n),
    .din      (din),
    .din_valid(din_valid),
    .frame_end(frame_end),
    .wren_out (wren_out),
    .wraddr   (wraddr),
    .wdata    (wdata),
    .pkt_done (pkt_done),
    .hdr_err  (hdr_err),
    .short_err(short_err),
    .bulk_ovf (bulk_ovf),
    .busy     (busy)
  );

  initial rdclock = 1'b0;
  always #5 rdclock = ~rdclock;

  typedef struct packed {
    logic [23:0] wren;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        done;
    logic        herr;
    logic        serr;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t mk(input logic [23:0] w, input logic [7:0] a,
                              input logic [31:0] d, input logic dn,
                              input logic he, input logic se);
    exp_t e;
    e.wren = w; e.addr = a; e.data = d; e.done = dn; e.herr = he; e.serr = se;
    return e;
  endfunction

  task automatic cyc(input logic v, input logic [31:0] d, input logic fe);
    din_valid = v;
    din       = d;
    frame_end = fe;
    @(negedge rdclock);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: any emitted beat must match the oldest expected beat
  always @(negedge rdclock) begin
    exp_t got, e;
    got = mk(wren_out, wraddr, wdata, pkt_done, hdr_err, short_err);
    if (rst_n && (wren_out != '0 || pkt_done || hdr_err || short_err)) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got wren=%h addr=%h data=%h done=%b herr=%b serr=%b",
                 got.wren, got.addr, got.data, got.done, got.herr, got.serr);
      end else begin
        e = q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL beat: got wren=%h addr=%h data=%h done=%b herr=%b serr=%b want wren=%h addr=%h data=%h done=%b herr=%b serr=%b",
                   got.wren, got.addr, got.data, got.done, got.herr, got.serr,
                   e.wren, e.addr, e.data, e.done, e.herr, e.serr);
        end
      end
    end
  end

  task automatic nav_packet();
    cyc(1'b1, 32'hFF000AAA, 1'b0);
    check("nav_busy_on", 32'(busy), 32'd1);
    for (int i = 0; i < 80; i++) begin
      q.push_back(mk(24'(1) << (8 + i / 10), 8'(i % 10), 32'h5000_0000 + 32'(i),
                     1'(i == 79), 1'b0, 1'b0));
      cyc(1'b1, 32'h5000_0000 + 32'(i), 1'(i == 79));
    end
    check("nav_busy_off", 32'(busy), 32'd0);
  endtask

  task automatic bulk_packet(input int bank, input int nwords, input logic fe_with_last);
    cyc(1'b1, 32'hFF0AAAAA, 1'b0);
    check("bulk_ovf_clr", 32'(bulk_ovf), 32'd0);
    for (int j = 0; j < nwords; j++) begin
      logic last;
      logic [31:0] d;
      last = fe_with_last && (j == nwords - 1);
      d = (j == 1) ? 32'hFF0000AA : 32'hB000_0000 + 32'(bank * 1024 + j);
      if (j < 256) q.push_back(mk(24'(1) << (16 + bank), 8'(j), d, last, 1'b0, 1'b0));
      else if (last) q.push_back(mk('0, '0, '0, 1'b1, 1'b0, 1'b0));
      cyc(1'b1, d, last);
    end
    if (!fe_with_last) begin
      q.push_back(mk('0, '0, '0, 1'b1, 1'b0, 1'b0));
      cyc(1'b0, 32'h0, 1'b1);
    end
  endtask

  initial begin
    rst_n = 1'b0; din = '0; din_valid = 1'b0; frame_end = 1'b0;
    repeat (3) @(negedge rdclock);
    check("rst_wren", 32'(wren_out), 32'd0);
    check("rst_flags", {27'd0, pkt_done, hdr_err, short_err, bulk_ovf, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge rdclock);

    // Non-header word and stray frame_end in IDLE produce nothing
    cyc(1'b1, 32'h1234_5678, 1'b0);
    cyc(1'b0, 32'h0, 1'b1);

    // Full C/A packet
    cyc(1'b1, 32'hFF0000AA, 1'b0);
    for (int k = 0; k < 256; k++) begin
      q.push_back(mk(24'(1) << (k / 32), 8'(k % 32), 32'(k), 1'(k == 255), 1'b0, 1'b0));
      cyc(1'b1, 32'(k), 1'b0);
    end
    check("ca_busy_off", 32'(busy), 32'd0);

    nav_packet();

    // Three back-to-back bulk packets, then sync resets the bank index
    bulk_packet(0, 5, 1'b1);
    bulk_packet(1, 5, 1'b0);
    bulk_packet(2, 5, 1'b0);
    q.push_back(mk('0, '0, '0, 1'b1, 1'b0, 1'b0));
    cyc(1'b1, 32'hFF00AAAA, 1'b0);
    bulk_packet(0, 3, 1'b0);

    // Overflowing bulk packet, then the next bulk header clears the flag
    bulk_packet(1, 300, 1'b1);
    check("bulk_ovf_set", 32'(bulk_ovf), 32'd1);
    bulk_packet(2, 2, 1'b0);

    // Unknown subtype
    q.push_back(mk('0, '0, '0, 1'b0, 1'b1, 1'b0));
    cyc(1'b1, 32'hFF1234AA, 1'b0);
    check("herr_idle", 32'(busy), 32'd0);

    // Truncated C/A packet
    cyc(1'b1, 32'hFF0000AA, 1'b0);
    for (int k = 0; k < 100; k++) begin
      q.push_back(mk(24'(1) << (k / 32), 8'(k % 32), 32'(k), 1'b0, 1'b0, 1'b0));
      cyc(1'b1, 32'(k), 1'b0);
    end
    q.push_back(mk('0, '0, '0, 1'b0, 1'b0, 1'b1));
    cyc(1'b0, 32'h0, 1'b1);
    check("short_idle", 32'(busy), 32'd0);

    // Reset mid C/A packet
    cyc(1'b1, 32'hFF0000AA, 1'b0);
    for (int k = 0; k < 50; k++) begin
      q.push_back(mk(24'(1) << (k / 32), 8'(k % 32), 32'(k), 1'b0, 1'b0, 1'b0));
      cyc(1'b1, 32'(k), 1'b0);
    end
    din = 32'd50;
    @(posedge rdclock);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wren", 32'(wren_out), 32'd0);
    check("midrst_data", wdata, 32'd0);
    check("midrst_busy", {30'd0, busy, pkt_done}, 32'd0);
    din_valid = 1'b0;
    repeat (2) @(negedge rdclock);
    rst_n = 1'b1;
    cyc(1'b1, 32'd51, 1'b0);
    cyc(1'b1, 32'd52, 1'b0);
    check("postrst_idle", 32'(busy), 32'd0);
    nav_packet();

    repeat (4) cyc(1'b0, 32'h0, 1'b0);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
